aes_round_sequencer: RTL and testbench

//  Sequences the byte-serial AES round datapath (SubBytes -> shiftrows -> MixColumns -> AddRoundKey)

---
 rtl/aes_round_sequencer_pkg.sv | 22 ++
 rtl/aes_round_sequencer_window_counter.sv | 42 ++++
 rtl/aes_round_sequencer.sv | 145 ++++++++++++++
 tb/tb_aes_round_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/aes_round_sequencer_pkg.sv
// Shared definitions for the byte-serial AES round sequencer.
package aes_round_sequencer_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_MAX_ROUNDS  = 14;
  localparam int CYC_W           = 6;
  localparam int RND_W           = $clog2(AES_MAX_ROUNDS + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_GAP   = 3'd2,
    ST_ROUND = 3'd3,
    ST_DRAIN = 3'd4
  } seq_state_t;

  // True in the states where a byte enters the datapath.
  function automatic logic is_inject(seq_state_t s);
    return (s == ST_LOAD) || (s == ST_ROUND);
  endfunction

endpackage

// File: rtl/aes_round_sequencer_window_counter.sv
// Window position counter: counts 0..ROUND_LAT-1 from each window's byte 0.
// Exposes the next position so the sequencer can register its outputs
// against the cycle they describe.
module aes_round_sequencer_window_counter
  import aes_round_sequencer_pkg::*;
#(
  parameter int ROUND_LAT = 18
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  output logic [CYC_W-1:0] cyc_nxt,
  output logic             terminal,
  output logic             byte_last
);

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(ROUND_LAT - 1);
  localparam logic [CYC_W-1:0] BYTE_LAST = CYC_W'(AES_BLOCK_BYTES - 1);

  logic [CYC_W-1:0] cyc;

  assign terminal  = (cyc == CYC_LAST);
  assign byte_last = (cyc == BYTE_LAST);

  // Restart on clear, wrap after the last cycle of a window, else advance.
  always_comb begin
    cyc_nxt = cyc + CYC_W'(1);
    if (clear || terminal) begin
      cyc_nxt = '0;
    end
  end

  // Window position register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc <= '0;
    end else begin
      cyc <= cyc_nxt;
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Control sequencer for the byte-serial AES round datapath: admits one
// 16-byte block, loops each round back through the datapath and drives
// frame sync, MixColumns bypass and key-schedule selects.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; all outputs low
//   ST_LOAD  | round 1 window: plaintext bytes 0..15 enter from the input
//   ST_GAP   | window cycles 16..ROUND_LAT-1, nothing injected
//   ST_ROUND | round 2..NR window: feedback bytes 0..15 re-enter
//   ST_DRAIN | final round output emerging: 16 ciphertext bytes
//
// Reset release is expected to be synchronous to clock upstream.
module aes_round_sequencer
  import aes_round_sequencer_pkg::*;
#(
  parameter int NR        = 10,
  parameter int ROUND_LAT = 18
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             in_ready,
  output logic             load_sel,
  output logic             inject,
  output logic             sr_frame,
  output logic             mc_bypass,
  output logic [RND_W-1:0] round,
  output logic [3:0]       byte_idx,
  output logic [RND_W-1:0] ark_round,
  output logic             ark_valid,
  output logic             out_valid,
  output logic             done
);

  localparam logic [RND_W-1:0] NR_L      = RND_W'(NR);
  localparam logic [CYC_W-1:0] BYTE_LAST = CYC_W'(AES_BLOCK_BYTES - 1);

  seq_state_t       state, state_nxt;
  logic [RND_W-1:0] rnd, rnd_nxt;
  logic [CYC_W-1:0] cyc_nxt;
  logic             terminal, byte_last, win_clear, inj_nxt;

  // The window counter is held at 0 while idle and restarted when a new
  // block follows the done cycle directly.
  assign win_clear = (state == ST_IDLE) || ((state == ST_DRAIN) && byte_last);
  assign inj_nxt   = is_inject(state_nxt);

  aes_round_sequencer_window_counter #(
    .ROUND_LAT (ROUND_LAT)
  ) u_window (
    .clock     (clock),
    .reset     (reset),
    .clear     (win_clear),
    .cyc_nxt   (cyc_nxt),
    .terminal  (terminal),
    .byte_last (byte_last)
  );

  // Next state and round; windows advance strictly on the counter wrap so
  // round spacing is exactly ROUND_LAT.
  always_comb begin
    state_nxt = state;
    rnd_nxt   = rnd;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_LOAD;
          rnd_nxt   = RND_W'(1);
        end
      end
      ST_LOAD, ST_ROUND, ST_GAP: begin
        if (terminal) begin
          if (rnd == NR_L) begin
            state_nxt = ST_DRAIN;
          end else begin
            state_nxt = ST_ROUND;
            rnd_nxt   = rnd + RND_W'(1);
          end
        end else if ((state != ST_GAP) && byte_last) begin
          state_nxt = ST_GAP;
        end
      end
      ST_DRAIN: begin
        if (byte_last) begin
          if (start) begin
            state_nxt = ST_LOAD;
            rnd_nxt   = RND_W'(1);
          end else begin
            state_nxt = ST_IDLE;
            rnd_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        rnd_nxt   = '0;
      end
    endcase
  end

  // State register plus outputs decoded from the state being entered, so
  // every output is a flop aligned with the cycle it describes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      rnd       <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      load_sel  <= 1'b0;
      inject    <= 1'b0;
      sr_frame  <= 1'b0;
      mc_bypass <= 1'b0;
      round     <= '0;
      byte_idx  <= '0;
      ark_round <= '0;
      ark_valid <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rnd       <= rnd_nxt;
      busy      <= (state_nxt != ST_IDLE);
      in_ready  <= (state_nxt == ST_LOAD);
      load_sel  <= (state_nxt == ST_LOAD);
      inject    <= inj_nxt;
      sr_frame  <= inj_nxt && (cyc_nxt == '0);
      mc_bypass <= inj_nxt && (rnd_nxt == NR_L);
      round     <= rnd_nxt;
      byte_idx  <= inj_nxt ? cyc_nxt[3:0] : 4'd0;
      ark_valid <= (state_nxt == ST_ROUND) || (state_nxt == ST_DRAIN);
      if (state_nxt == ST_ROUND) begin
        ark_round <= rnd_nxt - RND_W'(1);
      end else if (state_nxt == ST_DRAIN) begin
        ark_round <= NR_L;
      end else begin
        ark_round <= '0;
      end
      out_valid <= (state_nxt == ST_DRAIN);
      done      <= (state_nxt == ST_DRAIN) && (cyc_nxt == BYTE_LAST);
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: two instances (NR=10/LAT=18 and NR=1/LAT=16)
// share clock and reset; each accepted start pushes the block's first
// in_ready cycle to a scoreboard queue, and the expected output bundle for
// every cycle is derived from the block's timeline.
module tb_aes_round_sequencer;

  localparam int NR_A  = 10;
  localparam int LAT_A = 18;
  localparam int NR_B  = 1;
  localparam int LAT_B = 16;
  localparam int LAST_CYCLE = 1000;

  typedef struct packed {
    logic       busy;
    logic       in_ready;
    logic       load_sel;
    logic       inject;
    logic       sr_frame;
    logic       mc_bypass;
    logic [3:0] round;
    logic [3:0] byte_idx;
    logic [3:0] ark_round;
    logic       ark_valid;
    logic       out_valid;
    logic       done;
  } outs_t;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic       a_busy, a_in_ready, a_load_sel, a_inject, a_sr_frame, a_mc_bypass;
  logic [3:0] a_round, a_byte_idx, a_ark_round;
  logic       a_ark_valid, a_out_valid, a_done;
  logic       b_busy, b_in_ready, b_load_sel, b_inject, b_sr_frame, b_mc_bypass;
  logic [3:0] b_round, b_byte_idx, b_ark_round;
  logic       b_ark_valid, b_out_valid, b_done;

  outs_t obs_a, obs_b;
  assign obs_a = '{a_busy, a_in_ready, a_load_sel, a_inject, a_sr_frame, a_mc_bypass,
                   a_round, a_byte_idx, a_ark_round, a_ark_valid, a_out_valid, a_done};
  assign obs_b = '{b_busy, b_in_ready, b_load_sel, b_inject, b_sr_frame, b_mc_bypass,
                   b_round, b_byte_idx, b_ark_round, b_ark_valid, b_out_valid, b_done};

  aes_round_sequencer #(.NR(NR_A), .ROUND_LAT(LAT_A)) dut_a (
    .clock(clock), .reset(reset), .start(start_a),
    .busy(a_busy), .in_ready(a_in_ready), .load_sel(a_load_sel), .inject(a_inject),
    .sr_frame(a_sr_frame), .mc_bypass(a_mc_bypass), .round(a_round), .byte_idx(a_byte_idx),
    .ark_round(a_ark_round), .ark_valid(a_ark_valid), .out_valid(a_out_valid), .done(a_done)
  );

  aes_round_sequencer #(.NR(NR_B), .ROUND_LAT(LAT_B)) dut_b (
    .clock(clock), .reset(reset), .start(start_b),
    .busy(b_busy), .in_ready(b_in_ready), .load_sel(b_load_sel), .inject(b_inject),
    .sr_frame(b_sr_frame), .mc_bypass(b_mc_bypass), .round(b_round), .byte_idx(b_byte_idx),
    .ark_round(b_ark_round), .ark_valid(b_ark_valid), .out_valid(b_out_valid), .done(b_done)
  );

  always #5 clock = ~clock;

  int cycle = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int qa[$];
  int qb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cycle, obs, exp);
    end
  endtask

  // Expected outputs t cycles after a block's first in_ready cycle.
  function automatic outs_t model(input int nr, input int lat, input int t);
    outs_t e;
    int    w, p;
    e = '0;
    if (t < 0 || t >= nr * lat + 16) return e;
    e.busy = 1'b1;
    if (t < nr * lat) begin
      w = t / lat;
      p = t % lat;
      e.round    = 4'(w + 1);
      e.in_ready = (t < 16);
      e.load_sel = (t < 16);
      if (p < 16) begin
        e.inject    = 1'b1;
        e.byte_idx  = 4'(p);
        e.sr_frame  = (p == 0);
        e.mc_bypass = (w + 1 == nr);
        if (w >= 1) begin
          e.ark_valid = 1'b1;
          e.ark_round = 4'(w);
        end
      end
    end else begin
      e.round     = 4'(nr);
      e.ark_valid = 1'b1;
      e.ark_round = 4'(nr);
      e.out_valid = 1'b1;
      e.done      = (t == nr * lat + 15);
    end
    return e;
  endfunction

  task automatic check_dut(input string name, input int nr, input int lat, input outs_t obs,
                           input bit have, input int base, output bit pop);
    outs_t e;
    e   = have ? model(nr, lat, cycle - base) : '0;
    pop = 1'b0;
    chk({name, ".outs"}, 32'(obs), 32'(e));
    if (obs.done) begin
      chk({name, ".done_sb"}, 32'(have), 32'd1);
      if (have) begin
        chk({name, ".done_at"}, cycle, base + nr * lat + 15);
        pop = 1'b1;
      end
    end
  endtask

  function automatic bit start_a_at(input int c);
    return (c == 0) || (c == 50) || (c == 120) || (c == 196) || (c == 500) || (c == 610);
  endfunction

  function automatic bit start_b_at(input int c);
    return (c == 850) || (c >= 900 && c <= 960);
  endfunction

  // A start is accepted when idle or in the done cycle of the current block.
  task automatic drive_start(input bit sa, input bit sb);
    start_a = sa;
    start_b = sb;
    if (sa && !reset && (qa.size() == 0 || cycle >= qa[$] + NR_A * LAT_A + 15))
      qa.push_back(cycle + 1);
    if (sb && !reset && (qb.size() == 0 || cycle >= qb[$] + NR_B * LAT_B + 15))
      qb.push_back(cycle + 1);
  endtask

  initial begin
    bit pop_a, pop_b;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    for (cycle = 0; cycle < LAST_CYCLE; cycle++) begin
      if (cycle == 600) begin
        reset = 1'b1;
        qa.delete();
        qb.delete();
      end
      if (cycle == 605) reset = 1'b0;
      drive_start(start_a_at(cycle), start_b_at(cycle));
      @(negedge clock);
      check_dut("a", NR_A, LAT_A, obs_a, qa.size() > 0, (qa.size() > 0) ? qa[0] : 0, pop_a);
      check_dut("b", NR_B, LAT_B, obs_b, qb.size() > 0, (qb.size() > 0) ? qb[0] : 0, pop_b);
      if (pop_a) void'(qa.pop_front());
      if (pop_b) void'(qb.pop_front());
      case (cycle)
        0:   chk("reset_idle", 32'(obs_a), 32'd0);
        1:   chk("first_in_ready", {31'd0, a_in_ready}, 32'd1);
        19:  chk("r2_frame", {27'd0, a_sr_frame, a_round}, {27'd0, 1'b1, 4'd2});
        163: chk("r10_bypass", {27'd0, a_mc_bypass, a_round}, {27'd0, 1'b1, 4'd10});
        181: chk("first_out", {27'd0, a_out_valid, a_ark_round}, {27'd0, 1'b1, 4'd10});
        196: chk("first_done", {31'd0, a_done}, 32'd1);
        197: chk("b2b_load", {30'd0, a_busy, a_in_ready}, 32'd3);
        392: chk("second_done", {31'd0, a_done}, 32'd1);
        600: chk("reset_mid", 32'(obs_a), 32'd0);
        611: chk("post_reset_load", {31'd0, a_in_ready}, 32'd1);
        851: chk("nr1_bypass", {30'd0, b_mc_bypass, b_in_ready}, 32'd3);
        882: chk("nr1_done", {30'd0, b_out_valid, b_done}, 32'd3);
        default: ;
      endcase
      @(posedge clock);
      #1;
    end
    chk("sb_a_empty", 32'(qa.size()), 32'd0);
    chk("sb_b_empty", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
